mem_byte_responder: RTL and testbench

- Responder side of the byte-wide memory bus driven by the CPU memory controller. The bus signals are address, write data, write enable and read data.
- Serves a synchronous byte RAM with 1-cycle read latency, plus a small memory-mapped I/O window.
- The I/O window holds a TX byte FIFO (CPU to host) and an RX holding register (host to CPU).
- Sits between the memory controller and the board RAM/UART bridge.

---
 rtl/mem_byte_responder_pkg.sv | 12 +
 rtl/mem_byte_responder_byte_fifo.sv | 61 ++++++
 rtl/mem_byte_responder.sv | 135 +++++++++++++
 tb/tb_mem_byte_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_byte_responder_pkg.sv
// Shared constants for the byte-bus responder: I/O window offsets, status layout, miss value.
package mem_byte_responder_pkg;

  localparam logic [15:0] IO_TX_OFS   = 16'h0000;
  localparam logic [15:0] IO_STAT_OFS = 16'h0004;

  localparam int unsigned STAT_TX_FULL = 0;
  localparam int unsigned STAT_RX_FULL = 1;

  localparam logic [7:0] RD_MISS = 8'h00;

endpackage

// File: rtl/mem_byte_responder_byte_fifo.sv
// Byte FIFO with registered storage; head is forced to zero when empty.
module mem_byte_responder_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_byte_responder.sv
// Byte-bus responder: synchronous byte RAM plus an I/O window with TX FIFO and RX register.
module mem_byte_responder
  import mem_byte_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_wr_i,
  output logic [7:0]  mem_data_o,
  output logic [7:0]  io_tx_data_o,
  output logic        io_tx_valid_o,
  input  logic        io_tx_ready_i,
  input  logic [7:0]  io_rx_data_i,
  input  logic        io_rx_valid_i,
  output logic        io_rx_ready_o,
  output logic        io_ovf_o
);

  logic [7:0] ram_q [1 << ADDR_W];

  logic [7:0]  mem_data_q, mem_data_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_full_q, rx_full_d;
  logic        ovf_q, ovf_d;
  logic [31:0] prev_addr_q;
  logic [7:0]  prev_data_q;
  logic        prev_wr_q, prev_valid_q;

  logic              is_io, fire;
  logic [15:0]       io_ofs;
  logic [ADDR_W-1:0] ram_idx;
  logic              tx_push, tx_pop, tx_empty, tx_full;
  logic              rx_pop, rx_capture, ovf_clr;
  logic [7:0]        stat;

  assign is_io   = (mem_addr_i[31:16] == IO_BASE[31:16]);
  assign io_ofs  = mem_addr_i[15:0];
  assign ram_idx = mem_addr_i[ADDR_W-1:0];

  // The controller may park the bus; only a changed presentation triggers side effects.
  assign fire = ~prev_valid_q | (mem_addr_i != prev_addr_q) | (mem_wr_i != prev_wr_q) |
                (mem_data_i != prev_data_q);

  assign tx_push    = is_io & mem_wr_i & (io_ofs == IO_TX_OFS) & fire;
  assign rx_pop     = is_io & ~mem_wr_i & (io_ofs == IO_TX_OFS) & fire;
  assign ovf_clr    = is_io & mem_wr_i & (io_ofs == IO_STAT_OFS) & fire;
  assign tx_pop     = io_tx_valid_o & io_tx_ready_i;
  assign rx_capture = io_rx_valid_i & io_rx_ready_o;

  mem_byte_responder_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .data_i  (mem_data_i),
    .pop_i   (tx_pop),
    .data_o  (io_tx_data_o),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  assign io_tx_valid_o = ~tx_empty;
  assign io_rx_ready_o = ~rx_full_q & ~rst;
  assign io_ovf_o      = ovf_q;
  assign mem_data_o    = mem_data_q;

  always_comb begin
    stat               = RD_MISS;
    stat[STAT_TX_FULL] = tx_full;
    stat[STAT_RX_FULL] = rx_full_q;
  end

  always_comb begin
    mem_data_d = RD_MISS;
    if (is_io) begin
      if (!mem_wr_i) begin
        if (io_ofs == IO_TX_OFS)        mem_data_d = rx_full_q ? rx_data_q : RD_MISS;
        else if (io_ofs == IO_STAT_OFS) mem_data_d = stat;
      end
    end else begin
      // Write-first: a RAM write returns the byte just written.
      mem_data_d = mem_wr_i ? mem_data_i : ram_q[ram_idx];
    end
  end

  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (rx_capture) begin
      rx_full_d = 1'b1;
      rx_data_d = io_rx_data_i;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (tx_push & tx_full & ~tx_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_q   <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_full_q    <= 1'b0;
      ovf_q        <= 1'b0;
      prev_addr_q  <= '0;
      prev_data_q  <= '0;
      prev_wr_q    <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      mem_data_q   <= mem_data_d;
      rx_data_q    <= rx_data_d;
      rx_full_q    <= rx_full_d;
      ovf_q        <= ovf_d;
      prev_addr_q  <= mem_addr_i;
      prev_data_q  <= mem_data_i;
      prev_wr_q    <= mem_wr_i;
      prev_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr_i && !is_io) ram_q[ram_idx] <= mem_data_i;
  end

endmodule

// File: tb/tb_mem_byte_responder.sv
// Directed self-checking bench for mem_byte_responder.
module tb_mem_byte_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_data_i;
  logic        mem_wr_i;
  logic [7:0]  mem_data_o;
  logic [7:0]  io_tx_data_o;
  logic        io_tx_valid_o;
  logic        io_tx_ready_i;
  logic [7:0]  io_rx_data_i;
  logic        io_rx_valid_i;
  logic        io_rx_ready_o;
  logic        io_ovf_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_byte_responder dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_wr_i      (mem_wr_i),
    .mem_data_o    (mem_data_o),
    .io_tx_data_o  (io_tx_data_o),
    .io_tx_valid_o (io_tx_valid_o),
    .io_tx_ready_i (io_tx_ready_i),
    .io_rx_data_i  (io_rx_data_i),
    .io_rx_valid_i (io_rx_valid_i),
    .io_rx_ready_o (io_rx_ready_o),
    .io_ovf_o      (io_ovf_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    mem_addr_i = a;
    mem_wr_i   = w;
    mem_data_i = d;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    io_tx_ready_i = 1'b0;
    io_rx_data_i  = 8'h00;
    io_rx_valid_i = 1'b0;
    bus(32'h0, 1'b0, 8'h00);
    step();
    step();
    check("rst_mem_data", mem_data_o, 8'h00);
    check("rst_tx_valid", {7'b0, io_tx_valid_o}, 8'h00);
    check("rst_tx_data", io_tx_data_o, 8'h00);
    check("rst_ovf", {7'b0, io_ovf_o}, 8'h00);
    check("rst_rx_ready_low", {7'b0, io_rx_ready_o}, 8'h00);
    rst = 1'b0;
    #1;
    check("rx_ready_after_rst", {7'b0, io_rx_ready_o}, 8'h01);

    // RAM round trip and wrap
    bus(32'h0000_0000, 1'b1, 8'h11);
    step();
    bus(32'h0000_0100, 1'b1, 8'h5A);
    step();
    check("ram_write_first", mem_data_o, 8'h5A);
    bus(32'h0000_0100, 1'b0, 8'h00);
    step();
    check("ram_read", mem_data_o, 8'h5A);
    bus(32'h0002_0100, 1'b0, 8'h00);
    step();
    check("ram_read_wrap", mem_data_o, 8'h5A);

    // TX push and drain; I/O write leaves RAM[0] alone
    bus(32'h0003_0000, 1'b1, 8'h41);
    step();
    check("tx_valid_after_push", {7'b0, io_tx_valid_o}, 8'h01);
    check("tx_head", io_tx_data_o, 8'h41);
    bus(32'h0000_0000, 1'b0, 8'h00);
    io_tx_ready_i = 1'b1;
    step();
    io_tx_ready_i = 1'b0;
    check("tx_drained", {7'b0, io_tx_valid_o}, 8'h00);
    check("ram0_untouched", mem_data_o, 8'h11);

    // Idempotent hold: five identical write cycles push one byte
    bus(32'h0003_0000, 1'b1, 8'h42);
    repeat (5) step();
    bus(32'h0003_0004, 1'b0, 8'h00);
    step();
    check("stat_not_full", mem_data_o, 8'h00);
    check("hold_head", io_tx_data_o, 8'h42);
    io_tx_ready_i = 1'b1;
    step();
    io_tx_ready_i = 1'b0;
    check("hold_single_entry", {7'b0, io_tx_valid_o}, 8'h00);

    // Overflow: ninth distinct push is dropped
    for (int i = 1; i <= 9; i++) begin
      bus(32'h0003_0000, 1'b1, 8'(i));
      step();
    end
    check("ovf_set", {7'b0, io_ovf_o}, 8'h01);
    bus(32'h0003_0004, 1'b0, 8'h00);
    step();
    check("stat_tx_full", mem_data_o, 8'h01);
    bus(32'h0003_0004, 1'b1, 8'h00);
    step();
    check("ovf_cleared", {7'b0, io_ovf_o}, 8'h00);
    io_tx_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), io_tx_data_o, 8'(i));
      step();
    end
    io_tx_ready_i = 1'b0;
    check("drain_empty", {7'b0, io_tx_valid_o}, 8'h00);

    // RX path
    io_rx_data_i  = 8'h7E;
    io_rx_valid_i = 1'b1;
    step();
    io_rx_valid_i = 1'b0;
    check("rx_ready_low", {7'b0, io_rx_ready_o}, 8'h00);
    bus(32'h0003_0004, 1'b0, 8'h00);
    step();
    check("stat_rx_full", mem_data_o, 8'h02);
    bus(32'h0003_0000, 1'b0, 8'h00);
    step();
    check("rx_read", mem_data_o, 8'h7E);
    check("rx_ready_back", {7'b0, io_rx_ready_o}, 8'h01);
    bus(32'h0003_0004, 1'b0, 8'h00);
    step();
    check("stat_rx_empty", mem_data_o, 8'h00);
    bus(32'h0003_0000, 1'b0, 8'h00);
    step();
    check("rx_read_empty", mem_data_o, 8'h00);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      bus(32'h0003_0000, 1'b1, 8'hA1 + 8'(i));
      step();
    end
    bus(32'h0003_0004, 1'b0, 8'h00);
    io_rx_data_i  = 8'h55;
    io_rx_valid_i = 1'b1;
    step();
    io_rx_valid_i = 1'b0;
    step();
    check("pre_rst_stat", mem_data_o, 8'h02);
    check("pre_rst_head", io_tx_data_o, 8'hA1);
    rst = 1'b1;
    step();
    check("mid_rst_mem_data", mem_data_o, 8'h00);
    check("mid_rst_rx_ready", {7'b0, io_rx_ready_o}, 8'h00);
    rst = 1'b0;
    step();
    check("post_rst_tx_valid", {7'b0, io_tx_valid_o}, 8'h00);
    check("post_rst_tx_data", io_tx_data_o, 8'h00);
    check("post_rst_ovf", {7'b0, io_ovf_o}, 8'h00);
    check("post_rst_rx_ready", {7'b0, io_rx_ready_o}, 8'h01);
    check("post_rst_mem_data", mem_data_o, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
